// File: rtl/ad7908_spi_responder.sv
// ad7908_spi_responder
//   SPI slave emulating the serial interface of an 8-channel, 8-bit
//   successive-approximation ADC. All pins are oversampled on clk. The master
//   clocks a 12-bit control word in on MOSI while a 16-bit conversion frame
//   goes out on MISO: {1'b0, addr[2:0], data[7:0], 4'b0000}, MSB first.
//   A control write takes effect from the following frame.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   spi_sck       SPI clock from master (idle level arbitrary)
//   spi_cs_n      active-low frame select
//   spi_mosi      control word, MSB first, sampled on sck falling edge
//   spi_miso      conversion result, MSB first, updated after sck falling edge
//   ch_value      eight 8-bit channel values, channel n at [8n+7:8n]
//   cfg_addr      latched channel address
//   cfg_pm        latched PM1:PM0
//   cfg_range     latched RANGE bit (status only)
//   cfg_coding    latched CODING bit: 1 straight binary, 0 two's complement
//   frame_done    one-clk pulse when cs_n rises after 16 falling sck edges
//   frame_abort   one-clk pulse when cs_n rises early
module ad7908_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_ADDR  = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [63:0] ch_value,
  output logic [2:0]  cfg_addr,
  output logic [1:0]  cfg_pm,
  output logic        cfg_range,
  output logic        cfg_coding,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

  state_t state, state_nxt;

  // Pin synchronizers plus one history flop for edge detection.
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_fall, cs_fall, cs_rise;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_fall = sck_d & ~sck_s;
  assign cs_fall  = cs_d  & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  // The synchronizers come out of reset holding cs_n = 1, so a frame that was
  // already running when reset hit would look like a fresh cs_fall once the
  // chain flushes. Frames are only accepted after cs_n has been seen high
  // through a fully flushed chain, so a reset mid-frame waits for the next
  // genuine frame start.
  logic [SYNC_STAGES:0] flush_pipe;
  logic                 armed;
  logic                 cs_fall_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pipe <= '0;
      armed      <= 1'b0;
    end else begin
      flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
      if (flush_pipe[SYNC_STAGES] && cs_s) armed <= 1'b1;
    end
  end

  assign cs_fall_ok = cs_fall & armed;

  // Conversion data for the channel latched at the start of the frame.
  logic [7:0] samp;
  logic [7:0] conv_data;

  assign samp      = ch_value[{cfg_addr, 3'b000} +: 8];
  assign conv_data = cfg_coding ? samp : (samp ^ 8'h80);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall_ok) state_nxt = LOAD;
      LOAD:    state_nxt = cs_rise ? FINISH : SHIFT;
      SHIFT:   if (cs_rise) state_nxt = FINISH;
      FINISH:  state_nxt = cs_fall_ok ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [15:0] tx;
  logic [10:0] rx;   // first 11 control bits; the 12th is taken live from mosi
  logic [4:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_miso    <= 1'b0;
      tx          <= '0;
      rx          <= '0;
      cnt         <= '0;
      cfg_addr    <= RESET_ADDR;
      cfg_pm      <= 2'b11;
      cfg_range   <= 1'b0;
      cfg_coding  <= 1'b1;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        LOAD: begin
          tx       <= {1'b0, cfg_addr, conv_data, 4'b0000};
          rx       <= '0;
          cnt      <= '0;
          spi_miso <= 1'b0;
          if (cs_rise) frame_abort <= 1'b1;
        end
        SHIFT: begin
          // cs_rise takes priority; a coincident sck_fall is dropped.
          if (cs_rise) begin
            spi_miso <= 1'b0;
            if (cnt == 5'd16) frame_done  <= 1'b1;
            else              frame_abort <= 1'b1;
          end else if (sck_fall) begin
            if (cnt < 5'd12) rx <= {rx[9:0], mosi_s};
            // 12th edge: rx holds WRITE..RANGE, mosi_s carries CODING.
            if (cnt == 5'd11 && rx[10]) begin
              cfg_addr   <= rx[7:5];
              cfg_pm     <= rx[4:3];
              cfg_range  <= rx[0];
              cfg_coding <= mosi_s;
            end
            if (cnt != 5'd16) cnt <= cnt + 5'd1;
            // Zero-filling shift: once the frame is out, tx[14] stays 0, so
            // MISO idles low for the 16th and any extra edges.
            tx       <= {tx[14:0], 1'b0};
            spi_miso <= tx[14];
          end
        end
        default: spi_miso <= 1'b0;
      endcase
    end
  end

endmodule
